// File: rtl/idc_tile_stats.sv
// Purpose: capture a 4x4 tile of signed 7-bit pixels and drain per-row and per-column sums as 9-bit words.
// Latency: first word valid one cycle after the edge that accepts the 16th sample; then one word per handshake.
// Backpressure: words held stable until out_ready; pixels arriving while draining are discarded with a drop_err pulse.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_data     pixel strobe and signed 7-bit pixel, raster order
//   out_valid, out_ready  result word handshake
//   out_data, out_last    signed 9-bit result word, high with final word
//   busy                  high while the result words are being drained
//   drop_err              one-cycle pulse per discarded pixel
// Optional feature: define IDC_TILE_MINMAX_EN to append tile min and max words (10-word drain).
module idc_tile_stats (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic signed [6:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic signed [8:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              drop_err
);

`ifdef IDC_TILE_MINMAX_EN
    localparam logic [3:0] LAST_WP = 4'd9;
`else
    localparam logic [3:0] LAST_WP = 4'd7;
`endif

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t            state;
    logic [3:0]        idx;
    logic [3:0]        wp;
    logic [3:0]        sel;
    logic signed [8:0] row_sum [4];
    logic signed [8:0] col_sum [4];
    logic signed [8:0] sample_ext;
    logic signed [8:0] word_sel;
`ifdef IDC_TILE_MINMAX_EN
    logic signed [6:0] tile_min;
    logic signed [6:0] tile_max;
`endif

    assign sample_ext = {{2{in_data[6]}}, in_data};

    // The first DRAIN cycle (out_valid still low) loads word 0; afterwards the
    // mux looks one word ahead so the next word is ready on each handshake.
    assign sel = out_valid ? (wp + 4'd1) : 4'd0;

    always_comb begin
        word_sel = '0;
        case (sel)
            4'd0, 4'd1, 4'd2, 4'd3: word_sel = row_sum[sel[1:0]];
            4'd4, 4'd5, 4'd6, 4'd7: word_sel = col_sum[sel[1:0]];
`ifdef IDC_TILE_MINMAX_EN
            4'd8:                   word_sel = {{2{tile_min[6]}}, tile_min};
            4'd9:                   word_sel = {{2{tile_max[6]}}, tile_max};
`endif
            default:                word_sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            idx       <= '0;
            wp        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            drop_err  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                row_sum[i] <= '0;
                col_sum[i] <= '0;
            end
`ifdef IDC_TILE_MINMAX_EN
            tile_min <= 7'sd63;
            tile_max <= 7'b100_0000;    // -64
`endif
        end else begin
            drop_err <= (state == DRAIN) && in_valid;
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        row_sum[idx[3:2]] <= row_sum[idx[3:2]] + sample_ext;
                        col_sum[idx[1:0]] <= col_sum[idx[1:0]] + sample_ext;
`ifdef IDC_TILE_MINMAX_EN
                        if (in_data < tile_min) tile_min <= in_data;
                        if (in_data > tile_max) tile_max <= in_data;
`endif
                        if (idx == 4'd15) begin
                            state <= DRAIN;
                            idx   <= '0;
                            wp    <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_data  <= word_sel;
                        out_last  <= 1'b0;
                    end else if (out_ready) begin
                        if (wp == LAST_WP) begin
                            for (int i = 0; i < 4; i++) begin
                                row_sum[i] <= '0;
                                col_sum[i] <= '0;
                            end
`ifdef IDC_TILE_MINMAX_EN
                            tile_min <= 7'sd63;
                            tile_max <= 7'b100_0000;
`endif
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            state     <= COLLECT;
                        end else begin
                            wp       <= wp + 4'd1;
                            out_data <= word_sel;
                            out_last <= ((wp + 4'd1) == LAST_WP);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
